trng_reader: RTL and testbench

- Initiator and consumer for the 256-bit TRNG word interface. Fetches eight 32-bit words through the TRNG's en/addr/out/rdy port and assembles a 256-bit candidate.
- Rejection-samples the candidate against modulus P: keeps it only if it is below P, otherwise discards it and refetches.
- Presents accepted values to downstream crypto logic on a valid/ready stream.
- Sits between the trng block and its consumers; it is the only master of the TRNG port.

---
 rtl/trng_reader.sv | 144 ++++++++++++++
 tb/tb_trng_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_reader.sv
// Fetches eight 32-bit TRNG words, rejection-samples the 256-bit candidate
// against modulus P and presents accepted values on a valid/ready stream.
module trng_reader #(
    parameter logic [255:0] P = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               trng_en,
    output logic [2:0]         trng_addr,
    input  logic [31:0]        trng_data,
    input  logic               trng_rdy,
    output logic [255:0]       rnd_out,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic [CNT_W-1:0]   reject_cnt,
    output logic               err
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]       state_q, state_n;
    logic [2:0]       idx_q, idx_n;
    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic             got_q, got_n;
    logic [255:0]     cand_q, cand_n;
    logic [255:0]     out_n;
    logic             valid_n;
    logic [CNT_W-1:0] rej_n;
    logic             err_n;
    logic             en_n;

    assign trng_addr = idx_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tmo_q      <= '0;
            got_q      <= 1'b0;
            cand_q     <= '0;
            rnd_out    <= '0;
            rnd_valid  <= 1'b0;
            reject_cnt <= '0;
            err        <= 1'b0;
            trng_en    <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            tmo_q      <= tmo_n;
            got_q      <= got_n;
            cand_q     <= cand_n;
            rnd_out    <= out_n;
            rnd_valid  <= valid_n;
            reject_cnt <= rej_n;
            err        <= err_n;
            trng_en    <= en_n;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        tmo_n   = tmo_q;
        got_n   = got_q;
        cand_n  = cand_q;
        out_n   = rnd_out;
        valid_n = rnd_valid;
        rej_n   = reject_cnt;
        err_n   = err;

        case (state_q)
            IDLE: begin
                if (enable && !rnd_valid) begin
                    state_n = REQ;
                    idx_n   = 3'd0;
                    tmo_n   = '0;
                end
            end
            REQ: begin
                if (trng_rdy) begin
                    cand_n[{idx_q, 5'd0} +: 32] = trng_data;
                    tmo_n   = '0;
                    got_n   = 1'b1;
                    state_n = GAP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    tmo_n   = '0;
                    got_n   = 1'b0;
                    state_n = GAP;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                // A timed-out word is re-requested at the same index
                if (!got_q) begin
                    state_n = REQ;
                end else if (idx_q == 3'd7) begin
                    state_n = CHECK;
                end else begin
                    idx_n   = idx_q + 3'd1;
                    state_n = REQ;
                end
            end
            CHECK: begin
                if (cand_q < P) begin
                    out_n   = cand_q;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end else begin
                    if (reject_cnt != {CNT_W{1'b1}}) begin
                        rej_n = reject_cnt + CNT_W'(1);
                    end
                    idx_n   = 3'd0;
                    tmo_n   = '0;
                    state_n = REQ;
                end
            end
            HOLD: begin
                if (rnd_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        en_n = (state_n == REQ);
    end

endmodule

// File: tb/tb_trng_reader.sv
// Bench for trng_reader: TRNG responder, request-level reference model and
// a per-cycle compare process, driven by directed and randomized stimulus.
module tb_trng_reader;

    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 16;
    localparam logic [255:0] P      = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [255:0] P_M1   = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffe;
    localparam logic [255:0] ONES   = {256{1'b1}};
    localparam logic [255:0] SEQ    = 256'h0000000800000007000000060000000500000004000000030000000200000001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           trng_en;
    logic [2:0]     trng_addr;
    logic [31:0]    trng_data = 32'd0;
    logic           trng_rdy = 1'b0;
    logic [255:0]   rnd_out;
    logic           rnd_valid;
    logic           rnd_ready = 1'b0;
    logic [CW-1:0]  reject_cnt;
    logic           err;

    always #5 clk = ~clk;

    trng_reader #(.P(P), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .trng_en(trng_en), .trng_addr(trng_addr), .trng_data(trng_data), .trng_rdy(trng_rdy),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .reject_cnt(reject_cnt), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // TRNG responder: answers each request after a random delay; optional noise while idle
    logic [255:0] cand_q[$];
    int  wcnt = 0;
    int  dly = 0;
    int  max_dly = 0;
    bit  mute = 0;
    bit  silent = 0;
    bit  noise = 0;

    function automatic logic [31:0] word_for(input logic [2:0] a);
        logic [255:0] c;
        logic [31:0]  w;
        if (cand_q.size() > 0) begin
            c = cand_q[0];
            w = c[{a, 5'd0} +: 32];
            if (a == 3'd7) void'(cand_q.pop_front());
        end else begin
            w = $urandom;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        trng_rdy = 1'b0;
        if (trng_en) begin
            if (mute && trng_addr == 3'd3) begin
                silent = 1;
            end else if (wcnt >= dly) begin
                trng_rdy  = 1'b1;
                trng_data = word_for(trng_addr);
                wcnt = 0;
                dly  = $urandom_range(max_dly, 0);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (silent) begin
                mute = 0;
                silent = 0;
            end
            if (noise && $urandom_range(3, 0) == 0) begin
                trng_rdy  = 1'b1;
                trng_data = $urandom;
            end
        end
    end

    // Reference model: request/response view of a draw, updated at each edge
    logic [255:0] m_cand, m_out;
    logic [2:0]   m_addr;
    bit           m_valid, m_err, m_idle, m_req, m_gap;
    int           m_chk, m_run, n_acc;
    int unsigned  m_rej;

    always @(posedge clk) begin
        if (rst) begin
            m_cand = '0; m_out = '0; m_addr = 3'd0;
            m_valid = 0; m_err = 0; m_idle = 1; m_req = 0; m_gap = 0;
            m_chk = 0; m_run = 0; m_rej = 0;
        end else if (m_chk > 0) begin
            m_chk--;
            if (m_chk == 0) begin
                if (m_cand < P) begin
                    m_valid = 1; m_out = m_cand; n_acc++;
                end else begin
                    if (m_rej < 65535) m_rej++;
                    m_req = 1; m_run = 0;
                end
            end
        end else if (m_valid) begin
            if (rnd_ready) begin
                m_valid = 0; m_idle = 1;
            end
        end else if (m_idle) begin
            if (enable) begin
                m_idle = 0; m_req = 1; m_run = 0; m_addr = 3'd0;
            end
        end else if (m_req) begin
            if (trng_rdy) begin
                m_cand[{m_addr, 5'd0} +: 32] = trng_data;
                m_req = 0; m_run = 0;
                if (m_addr == 3'd7) begin
                    m_addr = 3'd0; m_chk = 2;
                end else begin
                    m_addr = m_addr + 3'd1; m_gap = 1;
                end
            end else begin
                m_run++;
                if (m_run == TMO) begin
                    m_err = 1; m_run = 0; m_req = 0; m_gap = 1;
                end
            end
        end else if (m_gap) begin
            m_gap = 0; m_req = 1;
        end
    end

    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("trng_en", trng_en, m_req);
            if (m_req) check("trng_addr", trng_addr, m_addr);
            check("rnd_valid", rnd_valid, m_valid);
            check("rnd_out", rnd_out, m_out);
            check("reject_cnt", reject_cnt, m_rej);
            check("err", err, m_err);
        end
    end

    task automatic wait_valid(input int lim, input string name);
        int n = 0;
        while (!rnd_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(name, rnd_valid, 1);
    endtask

    initial begin
        n_acc = 0;
        @(negedge clk);
        cmp_on = 1;
        check("rst_valid", rnd_valid, 0);
        check("rst_en", trng_en, 0);
        check("rst_out", rnd_out, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Word assembly and latency
        cand_q.push_back(SEQ);
        rnd_ready = 1'b1;
        enable = 1'b1;
        repeat (17) @(negedge clk);
        check("lat_early_valid", rnd_valid, 0);
        @(negedge clk);
        check("lat_valid", rnd_valid, 1);
        check("seq_out", rnd_out, SEQ);
        check("seq_rej", reject_cnt, 0);
        enable = 1'b0;
        repeat (10) @(negedge clk);

        // Rejection boundary and backpressure
        cand_q.push_back(ONES);
        cand_q.push_back(P);
        cand_q.push_back(P_M1);
        rnd_ready = 1'b0;
        enable = 1'b1;
        wait_valid(400, "rej_wait");
        check("rej_cnt2", reject_cnt, 2);
        check("rej_out", rnd_out, P_M1);
        repeat (20) begin
            @(negedge clk);
            check("bp_en", trng_en, 0);
            check("bp_out", rnd_out, P_M1);
        end
        rnd_ready = 1'b1;
        @(negedge clk);
        check("hs_valid", rnd_valid, 0);
        @(negedge clk);
        check("refetch_en", trng_en, 1);
        check("refetch_addr", trng_addr, 0);
        enable = 1'b0;
        wait_valid(100, "refetch_wait");
        repeat (5) @(negedge clk);

        // Timeout on word 3
        mute = 1;
        enable = 1'b1;
        begin
            int n = 0;
            while (!err && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("tmo_err", err, 1);
        wait_valid(300, "tmo_wait");
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Reset mid-fetch after word 4 is captured
        enable = 1'b1;
        begin
            int n = 0;
            bit hit = 0;
            while (!hit && n < 100) begin
                @(posedge clk);
                hit = trng_en && trng_rdy && trng_addr == 3'd4;
                n++;
            end
            check("rst_hit", hit, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en", trng_en, 0);
        check("mid_rst_valid", rnd_valid, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        wait_valid(100, "post_rst_wait");
        enable = 1'b0;
        repeat (5) @(negedge clk);

        // Randomized latency, noise, enable and backpressure
        max_dly = 5;
        noise = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 600 == 0) cand_q.push_back(P + 256'($urandom_range(3, 0)));
            enable = ($urandom_range(7, 0) != 0);
            rnd_ready = $urandom_range(1, 0);
        end
        check("progress", n_acc > 20, 1);
        noise = 0;
        enable = 1'b0;
        rnd_ready = 1'b1;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
